// File: rtl/custom_reg_ip_bank.sv
// Register bank behind a custom AXI peripheral: byte-strobed software writes,
// optional event counters with sticky overflow, and a change-driven readback channel per register.
module custom_reg_ip_bank_lane #(
  parameter int DW     = 32,
  parameter bit IS_CNT = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] be,
  input  logic          ev,
  input  logic          rdy,
  output logic          vld,
  output logic [DW-1:0] dout,
  output logic          ovf
);
  localparam int NB = DW / 8;

  logic          en_q, ev_q;
  logic [DW-1:0] wd_q;
  logic [NB-1:0] be_q;
  logic [DW-1:0] r, r_nxt;
  logic          d;
  logic          wr, inc, upd, launch;

  // Requests are registered first so R updates one edge after they are sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      ev_q <= 1'b0;
      wd_q <= '0;
      be_q <= '0;
    end else begin
      en_q <= en;
      ev_q <= ev;
      wd_q <= wdata;
      be_q <= be;
    end
  end

  assign wr     = en_q & (|be_q);
  assign inc    = IS_CNT & ev_q & ~wr;
  assign upd    = wr | inc;
  assign launch = d & (~vld | rdy);

  always_comb begin
    r_nxt = r;
    if (inc) begin
      r_nxt = r + DW'(1);
    end else if (wr) begin
      for (int b = 0; b < NB; b++)
        if (be_q[b]) r_nxt[b*8 +: 8] = wd_q[b*8 +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r    <= '0;
      d    <= 1'b0;
      ovf  <= 1'b0;
      vld  <= 1'b0;
      dout <= '0;
    end else begin
      r <= r_nxt;
      if (wr)               ovf <= 1'b0;
      else if (inc && &r)   ovf <= 1'b1;
      // An update landing on the launch edge keeps the channel dirty.
      d <= upd | (d & ~launch);
      if (launch) begin
        vld  <= 1'b1;
        dout <= r;
      end else if (rdy) begin
        vld <= 1'b0;
      end
    end
  end
endmodule

module custom_reg_ip_bank #(
  parameter int                  NUM_REGS = 4,
  parameter int                  DW       = 32,
  parameter logic [NUM_REGS-1:0] CNT_MASK = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REGS-1:0]      reg2ip_en_i,
  input  logic [NUM_REGS*DW-1:0]   reg2ip_data_i,
  input  logic [NUM_REGS*DW/8-1:0] reg2ip_be_i,
  input  logic [NUM_REGS-1:0]      hw_event_i,
  output logic [NUM_REGS-1:0]      ip2reg_valid_o,
  input  logic [NUM_REGS-1:0]      ip2reg_ready_i,
  output logic [NUM_REGS*DW-1:0]   ip2reg_data_o,
  output logic [NUM_REGS-1:0]      ovf_o
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lane
    custom_reg_ip_bank_lane #(
      .DW     (DW),
      .IS_CNT (CNT_MASK[i])
    ) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en     (reg2ip_en_i[i]),
      .wdata  (reg2ip_data_i[i*DW +: DW]),
      .be     (reg2ip_be_i[i*DW/8 +: DW/8]),
      .ev     (hw_event_i[i]),
      .rdy    (ip2reg_ready_i[i]),
      .vld    (ip2reg_valid_o[i]),
      .dout   (ip2reg_data_o[i*DW +: DW]),
      .ovf    (ovf_o[i])
    );
  end
endmodule

// File: tb/tb_custom_reg_ip_bank.sv
// Scoreboard bench for custom_reg_ip_bank: directed writes/events push expected
// readback values; a negedge monitor pops and compares on every transfer.
module tb_custom_reg_ip_bank;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]           en, ev, rdy, vld, ovf;
  logic [NR-1:0][DW-1:0]   wdata, dout;
  logic [NR-1:0][DW/8-1:0] be;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q [NR][$];

  always #5 clk = ~clk;

  custom_reg_ip_bank #(.NUM_REGS(NR), .DW(DW), .CNT_MASK(4'b0100)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .reg2ip_en_i    (en),
    .reg2ip_data_i  (wdata),
    .reg2ip_be_i    (be),
    .hw_event_i     (ev),
    .ip2reg_valid_o (vld),
    .ip2reg_ready_i (rdy),
    .ip2reg_data_o  (dout),
    .ovf_o          (ovf)
  );

  // Monitor: every handshake pops one expected value; stalled data must hold.
  initial begin
    logic [NR-1:0]         hold;
    logic [NR-1:0][DW-1:0] hold_d;
    logic [DW-1:0]         e;
    hold = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (hold[i] && vld[i]) begin
          tests++;
          if (dout[i] !== hold_d[i]) begin
            fails++;
            $display("FAIL hold_ch%0d: got %h, need %h", i, dout[i], hold_d[i]);
          end
        end
        if (vld[i] && rdy[i]) begin
          tests++;
          if (exp_q[i].size() == 0) begin
            fails++;
            $display("FAIL xfer_ch%0d: got unexpected %h, need no transfer", i, dout[i]);
          end else begin
            e = exp_q[i].pop_front();
            if (dout[i] !== e) begin
              fails++;
              $display("FAIL xfer_ch%0d: got %h, need %h", i, dout[i], e);
            end
          end
        end
        hold[i]   = vld[i] && !rdy[i] && rst_n;
        hold_d[i] = dout[i];
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] need);
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [DW-1:0] dat, input logic [3:0] b,
                       input logic e, input logic evt);
    en[ch] = e; wdata[ch] = dat; be[ch] = b; ev[ch] = evt;
    @(posedge clk); #1;
    en = '0; ev = '0; be = '0; wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = '0; ev = '0; be = '0; wdata = '0; rdy = '1;
    cycles(3);
    chk("reset_valid", 128'(vld), 128'(0));
    chk("reset_data", 128'(dout), 128'(0));
    chk("reset_ovf", 128'(ovf), 128'(0));
    rst_n = 1'b1;
    cycles(2);

    // Full write, single pulse on channel 0 only.
    exp_q[0].push_back(32'hDEADBEEF);
    drive(0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    cycles(6);

    // Partial strobe, then a zero-strobe write that must not send.
    exp_q[1].push_back(32'h11223344);
    drive(1, 32'h11223344, 4'hF, 1'b1, 1'b0);
    cycles(4);
    exp_q[1].push_back(32'h11BB33DD);
    drive(1, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0);
    cycles(4);
    drive(1, 32'h55555555, 4'h0, 1'b1, 1'b0);
    cycles(6);

    // Counter wrap with back-to-back events, then clearing write.
    exp_q[2].push_back(32'hFFFFFFFE);
    drive(2, 32'hFFFFFFFE, 4'hF, 1'b1, 1'b0);
    cycles(4);
    chk("ovf_before_wrap", 128'(ovf), 128'(0));
    exp_q[2].push_back(32'hFFFFFFFF);
    exp_q[2].push_back(32'h00000000);
    exp_q[2].push_back(32'h00000001);
    drive(2, '0, 4'h0, 1'b0, 1'b1);
    drive(2, '0, 4'h0, 1'b0, 1'b1);
    drive(2, '0, 4'h0, 1'b0, 1'b1);
    cycles(5);
    chk("ovf_after_wrap", 128'(ovf), 128'(4'b0100));
    exp_q[2].push_back(32'h00000000);
    drive(2, 32'h0, 4'hF, 1'b1, 1'b0);
    cycles(4);
    chk("ovf_cleared", 128'(ovf), 128'(0));

    // Backpressure: 1 held, 2 coalesced away, 3 sent next.
    rdy[0] = 1'b0;
    exp_q[0].push_back(32'd1);
    exp_q[0].push_back(32'd3);
    drive(0, 32'd1, 4'hF, 1'b1, 1'b0);
    cycles(4);
    drive(0, 32'd2, 4'hF, 1'b1, 1'b0);
    cycles(3);
    drive(0, 32'd3, 4'hF, 1'b1, 1'b0);
    cycles(4);
    chk("bp_valid", 128'(vld[0]), 128'(1));
    chk("bp_data", 128'(dout[0]), 128'(32'd1));
    rdy[0] = 1'b1;
    cycles(6);

    // Write beats a same-cycle event on the counter.
    exp_q[2].push_back(32'd5);
    drive(2, 32'd5, 4'hF, 1'b1, 1'b0);
    cycles(4);
    exp_q[2].push_back(32'h00000010);
    drive(2, 32'h10, 4'h1, 1'b1, 1'b1);
    cycles(6);
    chk("ovf_after_collision", 128'(ovf), 128'(0));

    // Reset mid-transfer with a pending update.
    rdy[0] = 1'b0;
    drive(0, 32'hA, 4'hF, 1'b1, 1'b0);
    cycles(4);
    drive(0, 32'hB, 4'hF, 1'b1, 1'b0);
    cycles(1);
    chk("pre_reset_valid", 128'(vld[0]), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 128'(vld), 128'(0));
    chk("async_reset_data", 128'(dout), 128'(0));
    chk("async_reset_ovf", 128'(ovf), 128'(0));
    cycles(2);
    rst_n = 1'b1;
    rdy = '1;
    cycles(10);

    for (int i = 0; i < NR; i++) begin
      tests++;
      if (exp_q[i].size() != 0) begin
        fails++;
        $display("FAIL drain_ch%0d: got %0d pending, need 0", i, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
